// File: rtl/pinwheel_pkg.sv
// Shared types for the pinwheel register-file write controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pinwheel_pkg;

  // Regfile data width is fixed for every pinwheel configuration.
  localparam int WORD_BITS = 32;

  // Controller phases: sweeping zeros into the regfile, or serving writers.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Identity of the two arbitrated write sources.
  typedef enum logic {
    REQ_LD  = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/pinwheel_rr_arb2.sv
// Two-way round-robin arbiter between load-return and debug writers.
// Latency: grants are combinational; only the fairness pointer is registered.
// Backpressure: en_i=0 withholds both grants; a grant is never given without its request.
module pinwheel_rr_arb2
  import pinwheel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_ld_i,
  input  logic req_dbg_i,
  output logic gnt_ld_o,
  output logic gnt_dbg_o
);

  // Requester that won most recently; the other one wins the next tie.
  req_id_t last_q;
  req_id_t last_d;

  // Pick a winner: lone requester wins, a tie goes to the one not served last.
  always_comb begin
    gnt_ld_o  = 1'b0;
    gnt_dbg_o = 1'b0;
    last_d    = last_q;
    if (en_i) begin
      if (req_ld_i && req_dbg_i) begin
        if (last_q == REQ_DBG) begin
          gnt_ld_o = 1'b1;
        end else begin
          gnt_dbg_o = 1'b1;
        end
      end else if (req_ld_i) begin
        gnt_ld_o = 1'b1;
      end else if (req_dbg_i) begin
        gnt_dbg_o = 1'b1;
      end
    end
    if (gnt_ld_o) begin
      last_d = REQ_LD;
    end else if (gnt_dbg_o) begin
      last_d = REQ_DBG;
    end
  end

  // Pointer register; reset pretends debug won last so load is favoured first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/pinwheel_regfile_ctrl.sv
// Regfile write-port controller: zero-clear sweep, then wb > round-robin(ld, dbg).
// Latency: a granted write reaches waddr/wdata/wren one cycle after the grant.
// Backpressure: wb never stalls (dropped during clear); ld/dbg stall on ready=0.
module pinwheel_regfile_ctrl
  import pinwheel_pkg::*;
#(
  parameter int reg_count    = 32,
  parameter int thread_count = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clear_req,
  input  logic                                       wb_valid,
  input  logic [$clog2(reg_count*thread_count)-1:0]  wb_addr,
  input  logic [WORD_BITS-1:0]                       wb_data,
  input  logic                                       ld_valid,
  output logic                                       ld_ready,
  input  logic [$clog2(reg_count*thread_count)-1:0]  ld_addr,
  input  logic [WORD_BITS-1:0]                       ld_data,
  input  logic                                       dbg_valid,
  output logic                                       dbg_ready,
  input  logic [$clog2(reg_count*thread_count)-1:0]  dbg_addr,
  input  logic [WORD_BITS-1:0]                       dbg_data,
  output logic [$clog2(reg_count*thread_count)-1:0]  waddr,
  output logic [WORD_BITS-1:0]                       wdata,
  output logic                                       wren,
  output logic                                       clear_done,
  output logic                                       wb_drop_err
);

  localparam int reg_total = reg_count * thread_count;
  localparam int addr_bits = $clog2(reg_total);
  localparam int word_bits = WORD_BITS;

  localparam logic [addr_bits-1:0] LAST_ADDR = addr_bits'(reg_total - 1);
  localparam logic [addr_bits-1:0] REG_CNT_W = addr_bits'(reg_count);

  state_t                 state_q, state_d;
  logic [addr_bits-1:0]   cnt_q, cnt_d;
  logic [addr_bits-1:0]   waddr_q, waddr_d;
  logic [word_bits-1:0]   wdata_q, wdata_d;
  logic                   wren_q, wren_d;
  logic                   drop_err_q, drop_err_d;

  logic                   arb_en;
  logic                   gnt_ld;
  logic                   gnt_dbg;
  logic                   sel_vld;
  logic [addr_bits-1:0]   sel_addr;
  logic [word_bits-1:0]   sel_data;

  // Writeback owns the port outright, so ld/dbg compete only when it is idle.
  assign arb_en = (state_q == ST_RUN) && !wb_valid;

  pinwheel_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (arb_en),
    .req_ld_i  (ld_valid),
    .req_dbg_i (dbg_valid),
    .gnt_ld_o  (gnt_ld),
    .gnt_dbg_o (gnt_dbg)
  );

  assign ld_ready    = gnt_ld;
  assign dbg_ready   = gnt_dbg;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign wren        = wren_q;
  assign clear_done  = (state_q == ST_RUN);
  assign wb_drop_err = drop_err_q;

  // Select the source that owns the write port this cycle while running.
  always_comb begin
    sel_vld  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (state_q == ST_RUN) begin
      if (wb_valid) begin
        sel_vld  = 1'b1;
        sel_addr = wb_addr;
        sel_data = wb_data;
      end else if (gnt_ld) begin
        sel_vld  = 1'b1;
        sel_addr = ld_addr;
        sel_data = ld_data;
      end else if (gnt_dbg) begin
        sel_vld  = 1'b1;
        sel_addr = dbg_addr;
        sel_data = dbg_data;
      end
    end
  end

  // Next state, clear sweep and registered write-port values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wren_d     = 1'b0;
    drop_err_d = drop_err_q;
    case (state_q)
      ST_CLEAR: begin
        waddr_d = cnt_q;
        wdata_d = '0;
        wren_d  = 1'b1;
        // Writeback cannot be stalled, so one arriving mid-sweep is lost.
        if (wb_valid) begin
          drop_err_d = 1'b1;
        end
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (sel_vld) begin
          waddr_d = sel_addr;
          wdata_d = sel_data;
          // x0 of every thread is hardwired zero: accept but suppress the write.
          wren_d  = ((sel_addr % REG_CNT_W) != '0);
        end
        // The grant in this cycle still lands; the sweep starts next cycle.
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sweep counter and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_pinwheel_regfile_ctrl.sv
// Bench for pinwheel_regfile_ctrl: directed scenarios followed by random traffic.
// Latency: expects writes one cycle after grant and a 128-cycle clear sweep.
// Backpressure: ld/dbg requesters hold address/data until accepted.
module tb_pinwheel_regfile_ctrl;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        wb_valid;
  logic [6:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [6:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [6:0]  waddr;
  logic [31:0] wdata;
  logic        wren;
  logic        clear_done;
  logic        wb_drop_err;

  pinwheel_regfile_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .dbg_valid   (dbg_valid),
    .dbg_ready   (dbg_ready),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .waddr       (waddr),
    .wdata       (wdata),
    .wren        (wren),
    .clear_done  (clear_done),
    .wb_drop_err (wb_drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the regfile port as seen from outside.
  bit          m_clear;
  int          m_idx;
  bit          m_last_dbg;
  bit          m_err;
  bit          m_wren;
  bit          m_known;
  logic [6:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_ldr;
  bit          m_dbr;
  bit          ld_acc;
  bit          dbg_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clear    = 1'b1;
    m_idx      = 0;
    m_last_dbg = 1'b1;
    m_err      = 1'b0;
    m_wren     = 1'b0;
    m_known    = 1'b1;
    m_waddr    = '0;
    m_wdata    = '0;
    ld_acc     = 1'b0;
    dbg_acc    = 1'b0;
  endtask

  task automatic model_eval();
    m_ldr = 1'b0;
    m_dbr = 1'b0;
    if (!m_clear && !wb_valid) begin
      if (ld_valid && dbg_valid) begin
        if (m_last_dbg) m_ldr = 1'b1;
        else            m_dbr = 1'b1;
      end else if (ld_valid) begin
        m_ldr = 1'b1;
      end else if (dbg_valid) begin
        m_dbr = 1'b1;
      end
    end
  endtask

  task automatic model_write(input logic [6:0] a, input logic [31:0] d);
    if ((int'(a) % 32) != 0) begin
      m_wren  = 1'b1;
      m_waddr = a;
      m_wdata = d;
      m_known = 1'b1;
    end else begin
      m_known = 1'b0;
    end
  endtask

  task automatic model_commit();
    m_wren = 1'b0;
    if (m_clear) begin
      m_wren  = 1'b1;
      m_waddr = 7'(m_idx);
      m_wdata = '0;
      m_known = 1'b1;
      if (wb_valid) m_err = 1'b1;
      m_idx++;
      if (m_idx == 128) m_clear = 1'b0;
    end else begin
      if (wb_valid) begin
        model_write(wb_addr, wb_data);
      end else if (m_ldr) begin
        model_write(ld_addr, ld_data);
        m_last_dbg = 1'b0;
      end else if (m_dbr) begin
        model_write(dbg_addr, dbg_data);
        m_last_dbg = 1'b1;
      end
      if (clear_req) begin
        m_clear = 1'b1;
        m_idx   = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("wren", wren, m_wren);
    chk("clear_done", clear_done, !m_clear);
    chk("wb_drop_err", wb_drop_err, m_err);
    if (m_known) begin
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
    end
  endtask

  // One clock: check readies against the model, then the registered outputs.
  task automatic tick();
    #1;
    model_eval();
    chk("ld_ready", ld_ready, m_ldr);
    chk("dbg_ready", dbg_ready, m_dbr);
    ld_acc  = m_ldr;
    dbg_acc = m_dbr;
    model_commit();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    clear_req = 1'b0;
    wb_valid  = 1'b0;
    ld_valid  = 1'b0;
    dbg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_wren", wren, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_err", wb_drop_err, 0);
    chk("rst_ldr", ld_ready, 0);
    chk("rst_dbr", dbg_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_wren", wren, 0);
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 128; i++) begin
      tick();
      chk({tag, "_wren"}, wren, 1);
      chk({tag, "_waddr"}, waddr, i);
      chk({tag, "_wdata"}, wdata, 0);
    end
    tick();
    chk({tag, "_done"}, clear_done, 1);
    chk({tag, "_end_wren"}, wren, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wb_addr = '0; wb_data = '0;
    ld_addr = '0; ld_data = '0;
    dbg_addr = '0; dbg_data = '0;
    ld_valid = 1'b1;
    #2;
    do_reset();
    idle();

    // Power-up sweep of zeros over all 128 entries.
    sweep_check("clr");

    // Writeback beats a concurrent load-return, which follows once wb drops.
    wb_valid = 1'b1; wb_addr = 7'h25; wb_data = 32'hDEADBEEF;
    ld_valid = 1'b1; ld_addr = 7'h13; ld_data = 32'h0000AAAA;
    #1;
    chk("wb_pri_ldr", ld_ready, 0);
    tick();
    chk("wb_waddr", waddr, 7'h25);
    chk("wb_wdata", wdata, 32'hDEADBEEF);
    chk("wb_wren", wren, 1);
    wb_valid = 1'b0;
    #1;
    chk("ld_after_wb", ld_ready, 1);
    tick();
    chk("ld_waddr", waddr, 7'h13);
    chk("ld_wdata", wdata, 32'h0000AAAA);
    ld_valid = 1'b0;

    // Debug wins alone, so the next tie must start with load.
    dbg_valid = 1'b1; dbg_addr = 7'h22; dbg_data = 32'h22;
    tick();
    ld_valid = 1'b1; ld_addr = 7'h01; ld_data = 32'h101;
    dbg_addr = 7'h02; dbg_data = 32'h202;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ld", ld_ready, (i % 2) == 0);
      chk("rr_dbg", dbg_ready, (i % 2) == 1);
      tick();
      chk("rr_waddr", waddr, ((i % 2) == 0) ? ld_addr : dbg_addr);
      chk("rr_wren", wren, 1);
      if ((i % 2) == 0) begin
        ld_addr = ld_addr + 7'd3; ld_data = ld_data + 32'd7;
      end else begin
        dbg_addr = dbg_addr + 7'd5; dbg_data = dbg_data + 32'd9;
      end
    end
    idle();

    // Write to x0 of thread 2 is accepted but suppressed.
    dbg_valid = 1'b1; dbg_addr = 7'h40; dbg_data = 32'h1234;
    #1;
    chk("x0_dbr", dbg_ready, 1);
    tick();
    chk("x0_wren", wren, 0);
    idle();

    // Clear request alongside an accepted load-return.
    clear_req = 1'b1;
    ld_valid = 1'b1; ld_addr = 7'h11; ld_data = 32'h5A5A0011;
    #1;
    chk("cr_ldr", ld_ready, 1);
    tick();
    chk("cr_waddr", waddr, 7'h11);
    chk("cr_wdata", wdata, 32'h5A5A0011);
    chk("cr_wren", wren, 1);
    idle();
    wb_valid = 1'b1; wb_addr = 7'h33; wb_data = 32'h77;
    clear_req = 1'b1;
    tick();
    chk("cr_sweep0", waddr, 0);
    chk("cr_err", wb_drop_err, 1);
    idle();
    clear_req = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    chk("cr_err_held", wb_drop_err, 1);
    chk("cr_no_restart", waddr, 60);

    // Reset mid-sweep with requests pending.
    wb_valid = 1'b1; ld_valid = 1'b1; dbg_valid = 1'b1;
    do_reset();
    idle();
    sweep_check("rclr");

    // Random traffic with requesters holding until accepted.
    for (int c = 0; c < 900; c++) begin
      clear_req = ($urandom_range(0, 99) == 0);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_addr   = 7'($urandom);
      wb_data   = $urandom;
      if (!ld_valid || ld_acc) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_addr  = 7'($urandom);
        if ($urandom_range(0, 7) == 0) ld_addr[4:0] = '0;
        ld_data  = $urandom;
      end
      if (!dbg_valid || dbg_acc) begin
        dbg_valid = 1'($urandom_range(0, 1));
        dbg_addr  = 7'($urandom);
        if ($urandom_range(0, 7) == 0) dbg_addr[4:0] = '0;
        dbg_data  = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
